// File: rtl/rv_decode_stage.sv
// rv_decode_stage: queued, back-pressured RV32I decode stage; define RV_M_EXT_EN to decode M-extension ops
package my_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [2:0] ALU_SRC_RS1_RS2 = 3'd0;
  localparam logic [2:0] ALU_SRC_RS1_IMM = 3'd1;
  localparam logic [2:0] ALU_SRC_PC_4    = 3'd2;
  localparam logic [2:0] ALU_SRC_PC_IMM  = 3'd3;
  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_JAL  = 3'd5;
  localparam logic [2:0] BR_JALR = 3'd6;
  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LH  = 3'd1;
  localparam logic [2:0] MEM_LW  = 3'd2;
  localparam logic [2:0] MEM_LBU = 3'd4;
  localparam logic [2:0] MEM_LHU = 3'd5;
  localparam logic [2:0] MEM_SB  = 3'd0;
  localparam logic [2:0] MEM_SH  = 3'd1;
  localparam logic [2:0] MEM_SW  = 3'd2;
endpackage

module rv_decode_stage #(
  parameter int DATA_WIDTH = my_pkg::DATA_WIDTH,
  parameter int IQ_DEPTH = 4,
  localparam int CNT_W = $clog2(IQ_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic [2:0]            mem_op,
  output logic [3:0]            alu_op,
  output logic [2:0]            alu_src,
  output logic [2:0]            branch,
  output logic                  illegal,
  output logic                  md_valid,
  output logic [2:0]            md_op,
  output logic [CNT_W-1:0]      iq_count
);
  import my_pkg::*;
  localparam int PW = $clog2(IQ_DEPTH);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [4:0] rs1, rs2, rd;
    logic mem_write, mem_to_reg, reg_write;
    logic [2:0] mem_op;
    logic [3:0] alu_op;
    logic [2:0] alu_src, branch;
    logic illegal, md_valid;
    logic [2:0] md_op;
  } bundle_t;
  logic [DATA_WIDTH-1:0] iq_inst [IQ_DEPTH];
  logic [DATA_WIDTH-1:0] iq_pc [IQ_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop;
  logic [31:0] h, imm, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [2:0] f3;
  logic [6:0] f7;
  bundle_t d, q;
  function automatic logic [3:0] alu_of(input logic [2:0] fn, input logic alt);
    case (fn)
      3'b000: return alt ? ALU_SUB : ALU_ADD;
      3'b001: return ALU_SLL;
      3'b010: return ALU_SLT;
      3'b011: return ALU_SLTU;
      3'b100: return ALU_XOR;
      3'b101: return alt ? ALU_SRA : ALU_SRL;
      3'b110: return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  assign in_ready = (count != CNT_W'(IQ_DEPTH)) && !flush;
  assign push = in_valid && in_ready;
  assign pop = (!out_valid || out_ready) && (count != '0) && !flush;
  assign h = iq_inst[rd_ptr][31:0];
  assign f3 = h[14:12];
  assign f7 = h[31:25];
  assign imm_i = {{20{h[31]}}, h[31:20]};
  assign imm_s = {{20{h[31]}}, h[31:25], h[11:7]};
  assign imm_b = {{19{h[31]}}, h[31], h[7], h[30:25], h[11:8], 1'b0};
  assign imm_u = {h[31:12], 12'b0};
  assign imm_j = {{11{h[31]}}, h[31], h[19:12], h[20], h[30:21], 1'b0};
  always_comb begin
    d = '0;
    imm = '0;
    d.pc = iq_pc[rd_ptr];
    d.rs1 = h[19:15];
    d.rs2 = h[24:20];
    d.rd = h[11:7];
    d.alu_src = ALU_SRC_RS1_IMM;
    case (h[6:2])
      5'b01100: begin
        d.alu_src = ALU_SRC_RS1_RS2;
        d.reg_write = 1'b1;
        d.alu_op = alu_of(f3, f7[5]);
        d.illegal = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
`ifdef RV_M_EXT_EN
        if (f7 == 7'h01) begin
          d.illegal = 1'b0;
          d.md_valid = 1'b1;
          d.md_op = f3;
          d.alu_op = ALU_ADD;
        end
`endif
      end
      5'b00000: begin
        d.mem_to_reg = 1'b1;
        d.reg_write = 1'b1;
        d.mem_op = f3;
        imm = imm_i;
        d.illegal = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      5'b00100: begin
        d.reg_write = 1'b1;
        d.alu_op = alu_of(f3, f3 == 3'b101 && f7[5]);
        imm = imm_i;
        d.illegal = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      5'b11000: begin
        d.alu_src = ALU_SRC_RS1_RS2;
        d.branch = f3[2] ? (f3[0] ? BR_BGE : BR_BLT) : (f3[0] ? BR_BNE : BR_BEQ);
        d.alu_op = !f3[2] ? ALU_SUB : f3[1] ? ALU_SLTU : ALU_SLT;
        imm = imm_b;
        d.illegal = f3[2:1] == 2'b01;
      end
      5'b11011: begin
        d.alu_src = ALU_SRC_PC_4;
        d.branch = BR_JAL;
        d.reg_write = 1'b1;
        imm = imm_j;
      end
      5'b11001: begin
        d.alu_src = ALU_SRC_PC_4;
        d.branch = BR_JALR;
        d.reg_write = 1'b1;
        imm = imm_i;
        d.illegal = f3 != 3'b000;
      end
      5'b01000: begin
        d.mem_write = 1'b1;
        d.mem_op = f3;
        imm = imm_s;
        d.illegal = f3 > 3'b010;
      end
      5'b01101: begin
        d.alu_op = ALU_LUI;
        d.reg_write = 1'b1;
        imm = imm_u;
      end
      5'b00101: begin
        d.alu_src = ALU_SRC_PC_IMM;
        d.reg_write = 1'b1;
        imm = imm_u;
      end
      default: d.illegal = 1'b1;
    endcase
    if (h[1:0] != 2'b11) d.illegal = 1'b1;
    // an undecodable word must not touch architectural state
    if (d.illegal) begin
      d.reg_write = 1'b0;
      d.mem_write = 1'b0;
      d.mem_to_reg = 1'b0;
      d.branch = BR_NONE;
      d.alu_op = ALU_ADD;
      d.md_valid = 1'b0;
      d.md_op = '0;
    end
    if (d.rd == 5'd0) d.reg_write = 1'b0;
    d.imm = DATA_WIDTH'($signed(imm));
  end
  always_ff @(posedge clk) begin
    if (push) begin
      iq_inst[wr_ptr] <= in_inst;
      iq_pc[wr_ptr] <= in_pc;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_valid <= 1'b0;
      q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop) begin
        out_valid <= 1'b1;
        q <= d;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
  assign out_pc = q.pc;
  assign out_imm = q.imm;
  assign out_rs1 = q.rs1;
  assign out_rs2 = q.rs2;
  assign out_rd = q.rd;
  assign mem_write = q.mem_write;
  assign mem_to_reg = q.mem_to_reg;
  assign reg_write = q.reg_write;
  assign mem_op = q.mem_op;
  assign alu_op = q.alu_op;
  assign alu_src = q.alu_src;
  assign branch = q.branch;
  assign illegal = q.illegal;
  assign md_valid = q.md_valid;
  assign md_op = q.md_op;
  assign iq_count = count;
endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: directed and randomized checks of rv_decode_stage against a behavioural model
module tb_rv_decode_stage;
  import my_pkg::*;
  localparam int IQ_DEPTH = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0] rs1, rs2, rd;
    logic mem_write, mem_to_reg, reg_write;
    logic [2:0] mem_op;
    logic [3:0] alu_op;
    logic [2:0] alu_src, branch;
    logic illegal, md_valid;
    logic [2:0] md_op;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0, in_pc = '0;
  logic in_ready, out_valid, mem_write, mem_to_reg, reg_write, illegal, md_valid;
  logic [31:0] out_pc, out_imm;
  logic [4:0] out_rs1, out_rs2, out_rd;
  logic [2:0] mem_op, alu_src, branch, md_op, iq_count;
  logic [3:0] alu_op;
  exp_t act;
  int total = 0, bad = 0;
  logic [31:0] mq_i[$], mq_p[$];
  logic mv = 1'b0;
  logic [31:0] mi = '0, mp = '0;
  rv_decode_stage #(.DATA_WIDTH(32), .IQ_DEPTH(IQ_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_op(mem_op),
    .alu_op(alu_op), .alu_src(alu_src), .branch(branch), .illegal(illegal),
    .md_valid(md_valid), .md_op(md_op), .iq_count(iq_count)
  );
  assign act = {out_pc, out_imm, out_rs1, out_rs2, out_rd, mem_write, mem_to_reg, reg_write,
                mem_op, alu_op, alu_src, branch, illegal, md_valid, md_op};
  always #5 clk = ~clk;
  function automatic void model(input logic [31:0] i, input logic [31:0] p, output exp_t e, output exp_t m);
    logic [3:0] tab [8];
    logic [3:0] btab_alu [8];
    logic [2:0] btab [8];
    logic [2:0] f3;
    logic [6:0] f7;
    int si;
    bit legal, wr, mem;
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    btab = '{BR_BEQ, BR_BNE, BR_NONE, BR_NONE, BR_BLT, BR_BGE, BR_BLT, BR_BGE};
    btab_alu = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
    f3 = i[14:12];
    f7 = i[31:25];
    si = int'(i);
    e = '0;
    m = '1;
    legal = 1'b1;
    wr = 1'b0;
    mem = 1'b0;
    e.pc = p;
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.rd = i[11:7];
    e.alu_op = ALU_ADD;
    e.alu_src = ALU_SRC_RS1_IMM;
    case (i[6:0])
      7'h33: begin
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.alu_op = f7 == 7'h20 ? (f3 == 0 ? ALU_SUB : ALU_SRA) : tab[f3];
        e.alu_src = ALU_SRC_RS1_RS2;
        wr = 1'b1;
        m.imm = '0;
`ifdef RV_M_EXT_EN
        if (f7 == 7'h01) begin
          legal = 1'b1;
          e.md_valid = 1'b1;
          e.md_op = f3;
          e.alu_op = ALU_ADD;
        end
`endif
      end
      7'h03: begin
        legal = !(f3 == 3 || f3 == 6 || f3 == 7);
        e.mem_to_reg = 1'b1;
        e.mem_op = f3;
        e.imm = 32'(si >>> 20);
        wr = 1'b1;
        mem = 1'b1;
      end
      7'h13: begin
        legal = f3 == 1 ? f7 == 0 : f3 == 5 ? (f7 == 0 || f7 == 7'h20) : 1'b1;
        e.alu_op = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : tab[f3];
        e.imm = 32'(si >>> 20);
        wr = 1'b1;
      end
      7'h63: begin
        legal = !(f3 == 2 || f3 == 3);
        e.branch = btab[f3];
        e.alu_op = btab_alu[f3];
        e.alu_src = ALU_SRC_RS1_RS2;
        e.imm = 32'(((si >>> 31) << 12) | (int'(i[7]) << 11) | (int'(i[30:25]) << 5) | (int'(i[11:8]) << 1));
      end
      7'h6F: begin
        e.branch = BR_JAL;
        e.alu_src = ALU_SRC_PC_4;
        e.imm = 32'(((si >>> 31) << 20) | (int'(i[19:12]) << 12) | (int'(i[20]) << 11) | (int'(i[30:21]) << 1));
        wr = 1'b1;
      end
      7'h67: begin
        legal = f3 == 0;
        e.branch = BR_JALR;
        e.alu_src = ALU_SRC_PC_4;
        e.imm = 32'(si >>> 20);
        wr = 1'b1;
      end
      7'h23: begin
        legal = f3 < 3;
        e.mem_write = 1'b1;
        e.mem_op = f3;
        e.imm = 32'(((si >>> 25) << 5) | int'(i[11:7]));
        mem = 1'b1;
      end
      7'h37: begin
        e.alu_op = ALU_LUI;
        e.imm = i & 32'hFFFFF000;
        wr = 1'b1;
      end
      7'h17: begin
        e.alu_src = ALU_SRC_PC_IMM;
        e.imm = i & 32'hFFFFF000;
        wr = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!mem) m.mem_op = '0;
    e.illegal = !legal;
    e.reg_write = legal && wr && e.rd != 0;
    if (!legal) begin
      e.mem_write = 1'b0;
      e.mem_to_reg = 1'b0;
      e.branch = BR_NONE;
      e.alu_op = ALU_ADD;
      e.md_valid = 1'b0;
      e.md_op = '0;
      m.imm = '0;
      m.mem_op = '0;
      m.alu_src = '0;
    end
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [9];
    logic [31:0] r;
    ops = '{7'h33, 7'h03, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h23, 7'h37, 7'h17};
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    r[6:0] = ops[$urandom_range(0, 8)];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction
  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p, input logic r, input logic f);
    in_valid = v;
    in_inst = i;
    in_pc = p;
    out_ready = r;
    flush = f;
  endtask
  task automatic step();
    bit ird, push, load;
    ird = (mq_i.size() < IQ_DEPTH) && !flush;
    push = in_valid && ird;
    load = (!mv || out_ready) && (mq_i.size() != 0) && !flush;
    @(posedge clk);
    if (flush) begin
      mq_i.delete();
      mq_p.delete();
      mv = 1'b0;
    end else begin
      if (load) begin
        mi = mq_i.pop_front();
        mp = mq_p.pop_front();
        mv = 1'b1;
      end else if (out_ready) mv = 1'b0;
      if (push) begin
        mq_i.push_back(in_inst);
        mq_p.push_back(in_pc);
      end
    end
    @(negedge clk);
  endtask
  task automatic issue(input logic [31:0] i, input logic [31:0] p);
    drive(1'b1, i, p, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({out_valid, iq_count, in_ready} !== {1'b0, 3'd0, 1'b1})
      begin bad++; $display("FAIL reset_ctrl got=%b req=%b", {out_valid, iq_count, in_ready}, 5'b00001); end
    total++;
    if (act !== '0) begin bad++; $display("FAIL reset_bundle got=%h req=0", act); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_decode();
    drive(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
    step();
    total++;
    if ({out_valid, iq_count} !== {1'b0, 3'd1}) begin bad++; $display("FAIL addi_latency got=%b req=0001", {out_valid, iq_count}); end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    total++;
    if ({out_valid, out_rd, out_rs1, out_imm, alu_op, alu_src, reg_write, illegal, out_pc} !==
        {1'b1, 5'd1, 5'd0, 32'd5, ALU_ADD, ALU_SRC_RS1_IMM, 1'b1, 1'b0, 32'h100})
      begin bad++; $display("FAIL addi got=%h", {out_valid, out_rd, out_rs1, out_imm, alu_op, alu_src, reg_write, illegal, out_pc}); end
    issue(32'h402081B3, 32'h104);
    total++;
    if ({alu_op, out_rd, illegal, reg_write} !== {ALU_SUB, 5'd3, 1'b0, 1'b1})
      begin bad++; $display("FAIL sub got=%h req=%h", {alu_op, out_rd, illegal, reg_write}, {ALU_SUB, 5'd3, 1'b0, 1'b1}); end
    issue(32'h00812283, 32'h108);
    total++;
    if ({mem_op, mem_to_reg, out_imm, out_rd, reg_write} !== {MEM_LW, 1'b1, 32'd8, 5'd5, 1'b1})
      begin bad++; $display("FAIL lw got=%h req=%h", {mem_op, mem_to_reg, out_imm, out_rd, reg_write}, {MEM_LW, 1'b1, 32'd8, 5'd5, 1'b1}); end
    issue(32'h00208863, 32'h10C);
    total++;
    if ({branch, alu_op, out_imm, reg_write, illegal} !== {BR_BEQ, ALU_SUB, 32'd16, 1'b0, 1'b0})
      begin bad++; $display("FAIL beq got=%h req=%h", {branch, alu_op, out_imm, reg_write, illegal}, {BR_BEQ, ALU_SUB, 32'd16, 1'b0, 1'b0}); end
    issue(32'h4010D093, 32'h110);
    total++;
    if ({alu_op, illegal, out_imm[4:0]} !== {ALU_SRA, 1'b0, 5'd1})
      begin bad++; $display("FAIL srai got=%h req=%h", {alu_op, illegal, out_imm[4:0]}, {ALU_SRA, 1'b0, 5'd1}); end
  endtask
  task automatic test_illegal();
    issue(32'h00003003, 32'h200);
    total++;
    if ({illegal, reg_write, mem_write, mem_to_reg, branch, alu_op} !== {4'b1000, BR_NONE, ALU_ADD})
      begin bad++; $display("FAIL ld_f3_011 got=%h", {illegal, reg_write, mem_write, mem_to_reg, branch, alu_op}); end
    issue(32'h00000013, 32'h204);
    total++;
    if ({illegal, reg_write, out_rd} !== {1'b0, 1'b0, 5'd0})
      begin bad++; $display("FAIL addi_x0 got=%b", {illegal, reg_write, out_rd}); end
    issue(32'h00500091, 32'h208);
    total++;
    if ({illegal, reg_write} !== 2'b10) begin bad++; $display("FAIL low_bits got=%b req=10", {illegal, reg_write}); end
    issue(32'h023100B3, 32'h20C);
    total++;
`ifdef RV_M_EXT_EN
    if ({illegal, md_valid, md_op, reg_write, alu_op, alu_src} !== {1'b0, 1'b1, 3'd0, 1'b1, ALU_ADD, ALU_SRC_RS1_RS2})
      begin bad++; $display("FAIL mul got=%h", {illegal, md_valid, md_op, reg_write, alu_op, alu_src}); end
`else
    if ({illegal, md_valid, md_op, reg_write} !== {1'b1, 1'b0, 3'd0, 1'b0})
      begin bad++; $display("FAIL mul got=%b req=100000", {illegal, md_valid, md_op, reg_write}); end
`endif
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, {12'(k), 5'd0, 3'd0, 5'd7, 7'h13}, 32'h400 + 32'(4 * k), 1'b1, 1'b0);
      step();
      if (k >= 1) begin
        total++;
        if ({out_valid, out_pc, out_imm, iq_count} !== {1'b1, 32'h400 + 32'(4 * (k - 1)), 32'(k - 1), 3'd1})
          begin bad++; $display("FAIL b2b_%0d got=%h", k, {out_valid, out_pc, out_imm, iq_count}); end
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) step();
  endtask
  task automatic test_backpressure();
    int acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, {12'(k), 5'd0, 3'd0, 5'(k + 1), 7'h13}, 32'h200 + 32'(4 * k), 1'b0, 1'b0);
      #1;
      if (in_ready) acc++;
      step();
    end
    total++;
    if ({acc[3:0], iq_count, in_ready, out_valid} !== {4'd5, 3'd4, 1'b0, 1'b1})
      begin bad++; $display("FAIL bp_full got=%0d/%0d/%b/%b req=5/4/0/1", acc, iq_count, in_ready, out_valid); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      total++;
      if ({out_valid, out_pc, out_rd} !== {1'b1, 32'h200 + 32'(4 * k), 5'(k + 1)})
        begin bad++; $display("FAIL bp_drain_%0d got=%h req=%h", k, {out_valid, out_pc, out_rd}, {1'b1, 32'h200 + 32'(4 * k), 5'(k + 1)}); end
      step();
    end
    total++;
    if ({out_valid, iq_count} !== 4'b0000) begin bad++; $display("FAIL bp_empty got=%b req=0000", {out_valid, iq_count}); end
  endtask
  task automatic test_flush();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h00100093, 32'h300 + 32'(4 * k), 1'b0, 1'b0);
      step();
    end
    total++;
    if ({iq_count, out_valid} !== {3'd3, 1'b1}) begin bad++; $display("FAIL fl_setup got=%b req=0111", {iq_count, out_valid}); end
    drive(1'b1, 32'h00200113, 32'h310, 1'b0, 1'b1);
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%b req=0", in_ready); end
    step();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    total++;
    if ({iq_count, out_valid} !== 4'b0000) begin bad++; $display("FAIL fl_clear got=%b req=0000", {iq_count, out_valid}); end
    step();
    total++;
    if ({iq_count, out_valid, in_ready} !== 5'b00001) begin bad++; $display("FAIL fl_nostore got=%b req=00001", {iq_count, out_valid, in_ready}); end
  endtask
  task automatic test_random();
    exp_t e, m;
    logic fl;
    for (int n = 0; n < 1500; n++) begin
      fl = $urandom_range(0, 19) == 0;
      drive($urandom_range(0, 9) < 7, rand_inst(), $urandom, $urandom_range(0, 9) < 6, fl);
      #1;
      total++;
      if (in_ready !== ((mq_i.size() < IQ_DEPTH) && !fl))
        begin bad++; $display("FAIL rnd_in_ready n=%0d got=%b q=%0d", n, in_ready, mq_i.size()); end
      step();
      total++;
      if ({out_valid, iq_count} !== {mv, 3'(mq_i.size())})
        begin bad++; $display("FAIL rnd_ctrl n=%0d got=%b/%0d req=%b/%0d", n, out_valid, iq_count, mv, mq_i.size()); end
      if (mv) begin
        model(mi, mp, e, m);
        total++;
        if ((act & m) !== (e & m))
          begin bad++; $display("FAIL rnd_bundle n=%0d inst=%h got=%h req=%h", n, mi, act & m, e & m); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered, back-pressured RV32I decode stage between fetch and execute.
- Buffers fetched instructions in a parametrised instruction queue (IQ) and decodes the queue head into the same control fields the single-cycle controller produces.
- Adds immediate generation, register indices, illegal-instruction detection, x0 write suppression and pipeline flush.
- Uses the shared my_pkg encodings (ALU_*, ALU_SRC_*, BR_*, MEM_*).

Parameters:
DATA_WIDTH, 32, instruction/immediate/pc width (my_pkg value)
IQ_DEPTH, 4, instruction queue entries; power of 2, >=2
CNT_W, $clog2(IQ_DEPTH)+1, occupancy counter width (derived, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all buffered/decoded instructions
in_valid  input  1  fetch offers instruction
in_ready  output  1  IQ can accept
in_inst  input  DATA_WIDTH  instruction word
in_pc  input  DATA_WIDTH  instruction pc
out_valid  output  1  decoded bundle valid
out_ready  input  1  execute accepts bundle
out_pc  output  DATA_WIDTH  pc of decoded instruction
out_imm  output  DATA_WIDTH  sign-extended immediate (I/S/B/U/J)
out_rs1, out_rs2, out_rd  output  5 each  register indices
mem_write, mem_to_reg, reg_write  output  1 each  as controller
mem_op  output  3  MEM_* code
alu_op  output  4  ALU_* code
alu_src  output  3  ALU_SRC_* code
branch  output  3  BR_* code
illegal  output  1  undecodable instruction
md_valid  output  1  multiply/divide op (optional feature)
md_op  output  3  M-extension funct3 (optional feature)
iq_count  output  CNT_W  IQ occupancy

Behaviour:
- Reset, asynchronous: IQ pointers and count 0; out_valid 0; all decoded outputs 0; out_pc/out_imm 0. in_ready is 1 after reset.
- IQ:
  - Circular FIFO, wrap-around pointers.
  - in_ready = !full && !flush.
  - Push on in_valid && in_ready.
  - No same-cycle bypass into the output register.
- Output register:
  - Loads when (!out_valid || out_ready) && iq_count != 0 && !flush. A load pops the IQ head.
  - If out_ready && out_valid and the IQ is empty, out_valid clears.
  - Simultaneous push and pop leaves iq_count unchanged.
- Latency: instruction pushed at edge N has out_valid high after edge N+1 when the output register is free. Sustained throughput is 1 instruction/cycle.
- While out_valid && !out_ready, the output bundle is held stable.
- flush has highest priority: next edge empties the IQ, clears out_valid, and drops any same-cycle push/pop. Decoded fields are don't-care when out_valid=0.
- Decode from registered head, by opcode[6:2]:
  - 01100 R-type
  - 00000 load
  - 00100 OP-IMM
  - 11000 branch
  - 11011 JAL (ALU_SRC_PC_4, BR_JAL)
  - 11001 JALR (ALU_SRC_PC_4, BR_JALR)
  - 01000 store
  - 01101 LUI (ALU_LUI)
  - 00101 AUIPC (ALU_SRC_PC_IMM)
  - Field values are identical to the single-cycle controller. blt/bge map to ALU_SLT; bltu/bgeu map to ALU_SLTU.
- Immediate sign extension uses inst[31] for all formats. Bit 0 is zero for B/J; U-type yields {inst[31:12],12'b0}.
- illegal=1 when any of:
  - opcode[1:0] != 2'b11 or unlisted opcode
  - load funct3 in {011,110,111}; store funct3 >= 011; branch funct3 in {010,011}
  - R-type funct7 not 0000000, or 0100000 with funct3 not in {000,101}
  - slli funct7 != 0; srli/srai funct7 not in {0000000,0100000}
  - JALR funct3 != 000
- When illegal=1: reg_write, mem_write, mem_to_reg = 0; branch = BR_NONE; alu_op = ALU_ADD.
- reg_write forced 0 when out_rd == 0. rd field otherwise reported unchanged.

Optional Feature:
- Macro RV_M_EXT_EN.
- Defined: R-type with funct7=0000001 is legal. It sets md_valid=1, md_op=funct3, reg_write=1 (rd!=0), alu_src=ALU_SRC_RS1_RS2, alu_op=ALU_ADD.
- Undefined: that encoding is illegal; md_valid and md_op are tied 0.

Test Plan:
- Reset release, then push 0x00500093 (addi x1,x0,5) at pc 0x100 -> two cycles later: out_valid=1, rd=1, rs1=0, imm=5, alu_op=ALU_ADD, alu_src=ALU_SRC_RS1_IMM, reg_write=1, out_pc=0x100.
- 0x402081B3 (sub x3,x1,x2) -> alu_op=ALU_SUB, rd=3, illegal=0. 0x00812283 (lw x5,8(x2)) -> mem_op=MEM_LW, mem_to_reg=1, imm=8.
- 0x00208863 (beq x1,x2,+16) -> branch=BR_BEQ, alu_op=ALU_SUB, imm=16, reg_write=0.
- Illegal/x0 cases:
  - 0x00003003 (funct3=011 load) -> illegal=1, all write enables 0.
  - 0x00000013 (addi x0) -> reg_write=0.
  - 0x023100B3 (mul) -> md_valid=1, md_op=0 with RV_M_EXT_EN; illegal=1 without.
- Back-pressure, IQ_DEPTH=4: out_ready=0, offer 6 instructions -> 5 accepted, iq_count=4, in_ready=0. Then out_ready=1 -> 5 bundles in order, one per cycle, no loss or duplication.
- With 3 queued and out_valid=1, assert flush together with in_valid -> next cycle iq_count=0, out_valid=0, the same-cycle instruction is not stored.
